// File: rtl/systolic_array_ctrl.sv
// Sequencer for an NxN systolic MAC array and its 2N operand FIFOs.
// It loads K operand vectors, streams them out with a per-lane skew so that
// row i and column j enter the array i and j cycles late, waits for the
// wavefront to drain, and then pulses done.
module systolic_array_ctrl #(
  parameter int N          = 3,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int PIPE_LAT   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] k_len,
  input  logic                       abort,
  input  logic                       load_valid,
  output logic                       load_ready,
  output logic [N-1:0]               row_w_en,
  output logic [N-1:0]               col_w_en,
  output logic [N-1:0]               row_r_en,
  output logic [N-1:0]               col_r_en,
  output logic                       array_clr,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int KW = $clog2(DEPTH+1);
  localparam int CW = $clog2(DEPTH+N+PIPE_LAT) + 1;
  // Last count value of the drain phase (drain lasts N-1+PIPE_LAT cycles).
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1 + PIPE_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t          state, nstate;
  logic [CW-1:0]   cnt, ncnt;
  logic [KW-1:0]   k_lat, nk;
  logic            clr_q, nclr;
  logic            err_q, nerr;
  logic [CW-1:0]   k_cw;
  logic [CW-1:0]   stream_last;
  logic [N-1:0]    win;
  logic            k_legal;

  assign k_cw        = CW'(k_lat);
  assign stream_last = k_cw + CW'(N - 1) - CW'(1);
  assign k_legal     = (k_len != '0) && (k_len <= KW'(DEPTH));

  // Skewed read window per lane: lane i is live for stream times i..i+K-1.
  // Rows and columns share the same skew, so one decode feeds both.
  for (genvar i = 0; i < N; i++) begin : g_win
    assign win[i] = (cnt >= CW'(i)) && (cnt < CW'(i) + k_cw);
  end

  // Next-state, counter and output decode; abort overrides everything.
  always_comb begin
    nstate     = state;
    ncnt       = cnt;
    nk         = k_lat;
    nclr       = 1'b0;
    nerr       = 1'b0;
    load_ready = 1'b0;
    row_w_en   = '0;
    col_w_en   = '0;
    row_r_en   = '0;
    col_r_en   = '0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (k_legal) begin
            nk     = k_len;
            ncnt   = '0;
            nclr   = 1'b1;
            nstate = S_LOAD;
          end else begin
            nerr = 1'b1;
          end
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        row_w_en   = {N{load_valid}};
        col_w_en   = {N{load_valid}};
        if (load_valid) begin
          if (cnt == k_cw - CW'(1)) begin
            ncnt   = '0;
            nstate = S_STREAM;
          end else begin
            ncnt = cnt + CW'(1);
          end
        end
      end
      S_STREAM: begin
        row_r_en = win;
        col_r_en = win;
        if (cnt == stream_last) begin
          ncnt   = '0;
          nstate = S_DRAIN;
        end else begin
          ncnt = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          ncnt   = '0;
          nstate = S_DONE;
        end else begin
          ncnt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        done   = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
    if (abort) begin
      nstate = S_IDLE;
      ncnt   = '0;
      nclr   = 1'b0;
      nerr   = 1'b0;
    end
  end

  // State, counter, latched K and the registered clear/error pulses.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      k_lat <= '0;
      clr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      k_lat <= nk;
      clr_q <= nclr;
      err_q <= nerr;
    end
  end

  assign array_clr = clr_q;
  assign err       = err_q;

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Sequencer for the NxN integer MAC systolic array and its 2N input FIFOs (N row FIFOs, N column FIFOs). It accepts a host load stream of K operand vectors and drives every FIFO write enable. It then issues skewed FIFO read enables so row i and column j enter the array i and j cycles late, waits for the wavefront to drain, and reports completion. It sits between the host/DMA and the array top level; the array's out_data_r_c are valid when done pulses.

Parameters:
N, 3, array dimension (rows = columns = N).
DEPTH, 8, FIFO depth; maximum legal K.
DATA_WIDTH, 16, operand width (pass-through only; controller does no arithmetic on data).
PIPE_LAT, 2, cycles from a FIFO r_en to its data being captured by the first PE.

Ports:
clk  in  1  clock, all state on rising edge.
rstn  in  1  reset; asynchronous, active-high (1 = reset asserted).
start  in  1  one-cycle request to run a job; honoured only in IDLE.
k_len  in  $clog2(DEPTH+1)  job length K; sampled with start.
abort  in  1  synchronous abort; returns to IDLE from any state.
load_valid  in  1  host has an operand vector (all 2N lanes) this cycle.
load_ready  out  1  controller accepts a vector this cycle.
row_w_en  out  N  write enable, bit i -> row FIFO i.
col_w_en  out  N  write enable, bit j -> column FIFO j.
row_r_en  out  N  read enable, bit i -> row FIFO i.
col_r_en  out  N  read enable, bit j -> column FIFO j.
array_clr  out  1  one-cycle clear pulse for PE accumulators.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when results are final.
err  out  1  one-cycle pulse when start is rejected for an illegal K.

Behaviour:
- Reset: state=IDLE, counters=0, latched K=0; all outputs 0. Assertion mid-job aborts immediately; FIFOs are reset by the same rstn.
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE: start with 1<=k_len<=DEPTH -> latch K, cnt=0, array_clr=1 next cycle (registered), go LOAD. start with k_len=0 or k_len>DEPTH -> err=1 next cycle, stay IDLE.
- LOAD: load_ready=1. row_w_en = col_w_en = {N{load_valid}}, combinational within LOAD only. Each accepted beat increments cnt. On the K-th accepted beat -> STREAM, cnt=0. Gaps in load_valid are tolerated indefinitely.
- STREAM: lasts exactly K+N-1 cycles, t=cnt=0..K+N-2. row_r_en[i]=(t>=i && t<i+K); col_r_en[j]=(t>=j && t<j+K). These are decoded from registered state/cnt and are glitch-free. No FIFO is ever read when empty, and each FIFO is read exactly K times. At t=K+N-2 -> DRAIN, cnt=0.
- DRAIN: N-1+PIPE_LAT cycles, all enables 0. Then -> DONE.
- DONE: done=1 for one cycle, busy=1, then -> IDLE.
- load_ready, all w_en and all r_en are 0 outside LOAD and STREAM respectively.
- start while busy: ignored, no err.
- abort: next state IDLE, no done, no err. Enables drop in the abort cycle's successor. Abort has priority over every other transition. FIFO contents left stale; the next job's array_clr clears the PEs, and the host must reset or drain the FIFOs.
- start and abort together in IDLE: abort wins, start ignored.
- Counter width: $clog2(DEPTH+N+PIPE_LAT)+1; no wrap within a legal job.

Test Plan:
- N=3, PIPE_LAT=2, start with K=3 at cycle 0, load_valid held high -> array_clr at 1; w_en=3'b111 at cycles 1-3; STREAM cycles 4-8 with row_r_en/col_r_en: 001,011,111,110,100; done=1 at cycle 13 only; busy 1-13.
- Load with load_valid toggling 1,0,0,1,1 for K=3 -> exactly 3 w_en pulses, each aligned with load_valid; STREAM starts the cycle after the 3rd beat.
- start with k_len=0, then with k_len=9 -> err pulse each time, busy stays 0, no enables.
- Abort in STREAM at t=2 -> r_en all 0 from the next cycle, state IDLE, no done. A following K=2 job completes normally with its own array_clr.
- rstn asserted mid-DRAIN -> all outputs 0 immediately, without waiting for a clock edge. After release, start is accepted.
- End-to-end with the array, K=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=identity -> at done, out_data_r_c equals A, with A[r][k] streamed via row r and B[k][c] via column c.
